barrier_driver: RTL
===================

BARRIER_DRIVER -- requirements
Module: barrier_driver

Interface
REQ-001 SHALL have parameter TRAVEL_TIMEOUT, default 200: maximum cycles allowed for a travel move, counted from entry to OPENING, CLOSING or HOMING.
REQ-002 SHALL have port clk, input, 1: single clock, rising edge.
REQ-003 SHALL have port reset_n, input, 1: asynchronous reset, active-low.
REQ-004 SHALL have port open_cmd, input, 1: synchronous open request from the parking control FSM.
REQ-005 SHALL have port close_cmd, input, 1: synchronous close request from the parking control FSM.
REQ-006 SHALL have port force_open, input, 1: synchronous emergency open level.
REQ-007 SHALL have port fault_clear, input, 1: synchronous operator fault acknowledge.
REQ-008 SHALL have ports limit_up, limit_down and obstacle, each input, 1, all asynchronous: barrier fully up, barrier fully down, and vehicle under the arm.
REQ-009 SHALL have ports motor_up and motor_down, each output, 1, registered: motor drive outputs.
REQ-010 SHALL have ports barrier_open, barrier_closed and fault, each output, 1, registered: status flags.
REQ-011 SHALL have port drv_state, output, 3, registered: current state code.

Function
REQ-012 SHALL pass limit_up, limit_down and obstacle through 2-flop synchronisers; the synchronised versions are called lu_s, ld_s and ob_s below.
REQ-013 SHALL implement exactly these states: HOMING, CLOSED, OPENING, OPEN, CLOSING, FAULT.
REQ-014 HOMING: SHALL go to CLOSED on ld_s, and to FAULT on timeout.
REQ-015 CLOSED: SHALL go to OPENING on open_cmd or force_open.
REQ-016 OPENING: SHALL go to OPEN on lu_s and to FAULT on timeout; close_cmd is ignored.
REQ-017 OPEN: SHALL go to CLOSING on close_cmd, but only when force_open=0 and ob_s=0.
REQ-018 CLOSING: SHALL go to OPENING (reversal, timer restarts) on ob_s, open_cmd or force_open; otherwise to CLOSED on ld_s; otherwise to FAULT on timeout.
REQ-019 FAULT: motors SHALL be off regardless of force_open; the state SHALL go to HOMING only on fault_clear.
REQ-020 In any state other than FAULT, lu_s=1 and ld_s=1 together SHALL force FAULT on the next edge; this has highest priority.
REQ-021 Simultaneous open_cmd and close_cmd SHALL be treated as open.
REQ-022 Timeout SHALL be defined as travel timer == TRAVEL_TIMEOUT; the timer SHALL be $clog2(TRAVEL_TIMEOUT+1) bits, clear on state entry, increment each cycle, and saturate.
REQ-023 Dead time: in the first cycle of OPENING, CLOSING or HOMING both motor outputs SHALL be 0; motor_up (OPENING) or motor_down (CLOSING, HOMING) SHALL assert from the second cycle.
REQ-024 In HOMING, motor_down SHALL be held 0 while ob_s=1.
REQ-025 motor_up and motor_down SHALL never be 1 in the same cycle.
REQ-026 All outputs SHALL be decoded from next state and registered, so outputs change on the same edge as the state register.
REQ-027 barrier_open SHALL equal (state==OPEN), barrier_closed SHALL equal (state==CLOSED), and fault SHALL equal (state==FAULT).
REQ-028 Latency from a limit/obstacle input change to the resulting state/output change SHALL be 3 edges: 2 synchroniser edges plus 1 state edge.

Reset
REQ-029 reset_n=0 SHALL asynchronously force state HOMING, clear the timer and synchronisers, and set all outputs to 0 (drv_state=HOMING code).
REQ-030 Reset asserted mid-travel SHALL drop the motors immediately; after release, the block SHALL re-home with dead time applied.

Structure
REQ-031 State codes (HOMING=000, CLOSED=001, OPENING=010, OPEN=011, CLOSING=100, FAULT=111) and the TRAVEL_TIMEOUT default SHALL reside in shared package barrier_pkg.
REQ-032 The 2-flop synchroniser SHALL be a separate sub-module sync_2ff, instantiated three times.

Verification (TRAVEL_TIMEOUT=8)
REQ-033 Home: release reset with limit_down=1 -> drv_state=HOMING, motor_down=0 at edge 1 (dead time), barrier_closed=1 at edge 3.
REQ-034 Open: CLOSED, pulse open_cmd -> OPENING, motor_up=1 from the 2nd OPENING cycle; raise limit_up -> OPEN and motor_up=0 exactly 3 edges later.
REQ-035 Obstacle reversal: in CLOSING with motor_down=1, raise obstacle -> OPENING after 3 edges, with one cycle of both motors 0 before motor_up=1.
REQ-036 Timeout: OPENING with limit_up held 0 -> FAULT after 8 cycles with motors 0; force_open=1 keeps motors 0; fault_clear -> HOMING.
REQ-037 Sensor conflict: in OPEN, drive limit_up=1 and limit_down=1 -> FAULT 3 edges later.
REQ-038 Conflict: in CLOSED, assert open_cmd and close_cmd together -> OPENING; assert close_cmd in OPEN with obstacle=1 -> remains OPEN.

Source files
------------

// File: rtl/barrier_pkg.sv
// ---------------------------------------------------------------------------
// barrier_pkg : shared state codes and defaults for the barrier driver. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package barrier_pkg;

  localparam int unsigned C_TRAVEL_TIMEOUT = 200;

  typedef enum logic [2:0] {
    ST_HOMING  = 3'b000,
    ST_CLOSED  = 3'b001,
    ST_OPENING = 3'b010,
    ST_OPEN    = 3'b011,
    ST_CLOSING = 3'b100,
    ST_FAULT   = 3'b111
  } drv_state_e;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff : two-flop synchroniser for asynchronous single-bit inputs. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/barrier_driver.sv
// ---------------------------------------------------------------------------
// barrier_driver : parking barrier motor sequencer with dead time. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module barrier_driver
  import barrier_pkg::*;
#(
  parameter int unsigned TRAVEL_TIMEOUT = C_TRAVEL_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       open_cmd,
  input  logic       close_cmd,
  input  logic       force_open,
  input  logic       fault_clear,
  input  logic       limit_up,
  input  logic       limit_down,
  input  logic       obstacle,
  output logic       motor_up,
  output logic       motor_down,
  output logic       barrier_open,
  output logic       barrier_closed,
  output logic       fault,
  output logic [2:0] drv_state
);

  localparam int unsigned C_TIMER_W = $clog2(TRAVEL_TIMEOUT + 1);

  logic                 w_lu_s;
  logic                 w_ld_s;
  logic                 w_ob_s;
  drv_state_e           r_state;
  drv_state_e           w_next;
  logic [C_TIMER_W-1:0] r_timer;
  logic                 r_armed;
  logic                 w_entering;
  logic                 w_timeout;
  logic                 r_motor_up;
  logic                 r_motor_down;
  logic                 r_open;
  logic                 r_closed;
  logic                 r_fault;

  sync_2ff u_sync_lu (.clk(clk), .reset_n(reset_n), .d(limit_up),   .q(w_lu_s));
  sync_2ff u_sync_ld (.clk(clk), .reset_n(reset_n), .d(limit_down), .q(w_ld_s));
  sync_2ff u_sync_ob (.clk(clk), .reset_n(reset_n), .d(obstacle),   .q(w_ob_s));

  assign w_timeout  = (r_timer == C_TIMER_W'(TRAVEL_TIMEOUT));
  // The first edge after reset counts as an entry so HOMING also gets dead time.
  assign w_entering = (w_next != r_state) || !r_armed;

  always_comb begin
    w_next = r_state;
    if (r_state != ST_FAULT && w_lu_s && w_ld_s) begin
      w_next = ST_FAULT;
    end else begin
      case (r_state)
        ST_HOMING: begin
          if (w_ld_s)         w_next = ST_CLOSED;
          else if (w_timeout) w_next = ST_FAULT;
        end
        ST_CLOSED: begin
          if (open_cmd || force_open) w_next = ST_OPENING;
        end
        ST_OPENING: begin
          if (w_lu_s)         w_next = ST_OPEN;
          else if (w_timeout) w_next = ST_FAULT;
        end
        ST_OPEN: begin
          if (close_cmd && !open_cmd && !force_open && !w_ob_s) w_next = ST_CLOSING;
        end
        ST_CLOSING: begin
          if (w_ob_s || open_cmd || force_open) w_next = ST_OPENING;
          else if (w_ld_s)                      w_next = ST_CLOSED;
          else if (w_timeout)                   w_next = ST_FAULT;
        end
        ST_FAULT: begin
          if (fault_clear) w_next = ST_HOMING;
        end
        default: w_next = ST_HOMING;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_HOMING;
      r_timer      <= '0;
      r_armed      <= 1'b0;
      r_motor_up   <= 1'b0;
      r_motor_down <= 1'b0;
      r_open       <= 1'b0;
      r_closed     <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_armed <= 1'b1;
      if (w_entering)      r_timer <= '0;
      else if (!w_timeout) r_timer <= r_timer + C_TIMER_W'(1);
      r_motor_up   <= !w_entering && (w_next == ST_OPENING);
      r_motor_down <= !w_entering &&
                      ((w_next == ST_CLOSING) || (w_next == ST_HOMING && !w_ob_s));
      r_open       <= (w_next == ST_OPEN);
      r_closed     <= (w_next == ST_CLOSED);
      r_fault      <= (w_next == ST_FAULT);
    end
  end

  assign motor_up       = r_motor_up;
  assign motor_down     = r_motor_down;
  assign barrier_open   = r_open;
  assign barrier_closed = r_closed;
  assign fault          = r_fault;
  assign drv_state      = r_state;

endmodule

`default_nettype wire
